// File: rtl/bank_interleave_ctrl.sv
// N-bank interleaved controller: one read port and one write port mapped onto
// single-port bank RAMs, with a one-entry write-hold buffer for same-bank conflicts.
module bank_interleave_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int BANK_BITS = 1,
    parameter int CNT_W     = 16,
    localparam int NB       = 2 ** BANK_BITS,
    localparam int RW       = ADDR_W - BANK_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 re,
    input  logic [ADDR_W-1:0]    r_adr,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    w_adr,
    input  logic [DATA_W-1:0]    w_data,
    output logic                 w_ready,
    output logic [NB-1:0]        bank_en,
    output logic [NB-1:0]        bank_we,
    output logic [NB*RW-1:0]     bank_a,
    output logic [NB*DATA_W-1:0] bank_di,
    input  logic [NB*DATA_W-1:0] bank_do,
    output logic                 rd_valid,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 hold_valid,
    output logic [CNT_W-1:0]     conflict_cnt
);

    logic                 hold_valid_q, hold_valid_d;
    logic [ADDR_W-1:0]    hold_adr_q, hold_adr_d;
    logic [DATA_W-1:0]    hold_data_q, hold_data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rd_valid_q;
    logic [BANK_BITS-1:0] rd_bank_q;
    logic                 fwd_q;
    logic [DATA_W-1:0]    fwd_data_q;

    logic                 cand_v;
    logic [ADDR_W-1:0]    cand_adr;
    logic [DATA_W-1:0]    cand_data;
    logic [BANK_BITS-1:0] rbank, cbank;
    logic [RW-1:0]        rrow, crow;
    logic                 conflict;
    logic                 issue;
    logic [DATA_W-1:0]    do_lane [NB];

    // The held write always takes the candidate slot; new writes are stalled meanwhile.
    always_comb begin
        cand_v    = hold_valid_q | we;
        cand_adr  = hold_valid_q ? hold_adr_q  : w_adr;
        cand_data = hold_valid_q ? hold_data_q : w_data;
        rbank     = r_adr[BANK_BITS-1:0];
        rrow      = r_adr[ADDR_W-1:BANK_BITS];
        cbank     = cand_adr[BANK_BITS-1:0];
        crow      = cand_adr[ADDR_W-1:BANK_BITS];
        conflict  = re & cand_v & (cbank == rbank);
        issue     = cand_v & ~conflict & ~rst;
    end

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic rd_hit;
            logic wr_hit;
            assign rd_hit  = re & ~rst & (rbank == BANK_BITS'(gi));
            assign wr_hit  = issue & (cbank == BANK_BITS'(gi));
            assign bank_en[gi]                = rd_hit | wr_hit;
            assign bank_we[gi]                = wr_hit;
            assign bank_a[gi*RW +: RW]        = wr_hit ? crow : rrow;
            assign bank_di[gi*DATA_W +: DATA_W] = cand_data;
            assign do_lane[gi]                = bank_do[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_adr_d   = hold_adr_q;
        hold_data_d  = hold_data_q;
        cnt_d        = cnt_q;
        if (hold_valid_q) begin
            if (!conflict) begin
                hold_valid_d = 1'b0;
            end
        end else if (we && conflict) begin
            hold_valid_d = 1'b1;
            hold_adr_d   = w_adr;
            hold_data_d  = w_data;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_adr_q   <= '0;
            hold_data_q  <= '0;
            cnt_q        <= '0;
            rd_valid_q   <= 1'b0;
            rd_bank_q    <= '0;
            fwd_q        <= 1'b0;
            fwd_data_q   <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_adr_q   <= hold_adr_d;
            hold_data_q  <= hold_data_d;
            cnt_q        <= cnt_d;
            rd_valid_q   <= re;
            rd_bank_q    <= rbank;
            // A read of the held address must see the held data, not stale RAM.
            fwd_q        <= re & hold_valid_q & (hold_adr_q == r_adr);
            fwd_data_q   <= hold_data_q;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_valid_q) begin
            rd_data = fwd_q ? fwd_data_q : do_lane[rd_bank_q];
        end
    end

    assign w_ready      = ~hold_valid_q;
    assign hold_valid   = hold_valid_q;
    assign conflict_cnt = cnt_q;
    assign rd_valid     = rd_valid_q;

endmodule
